// File: rtl/spi_master_stream.sv
// SPI mode-0 master: serialises one parallel word per SS-framed transfer and
// returns the MISO word captured during the same frame as a one-cycle pulse.
module spi_master_stream #(
    parameter int WIDTH      = 16,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_busy,
    output logic             o_sclk,
    output logic             o_mosi,
    output logic             o_ss,
    input  logic             i_miso
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLK_DIV);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t            state_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [GAP_W-1:0]  gap_reg;
    logic [BIT_W-1:0]  bit_reg;
    logic [WIDTH-1:0]  tx_sr_reg;
    logic [WIDTH-1:0]  rx_sr_reg;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_reg  <= IDLE;
            div_reg    <= '0;
            gap_reg    <= '0;
            bit_reg    <= '0;
            tx_sr_reg  <= '0;
            rx_sr_reg  <= '0;
            o_tx_ready <= 1'b0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_sclk     <= 1'b0;
            o_mosi     <= 1'b0;
            o_ss       <= 1'b1;
        end else begin
            o_rx_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_tx_valid && o_tx_ready) begin
                        tx_sr_reg  <= i_tx_data;
                        rx_sr_reg  <= '0;
                        o_tx_ready <= 1'b0;
                        o_busy     <= 1'b1;
                        div_reg    <= '0;
                        state_reg  <= SETUP;
                    end else begin
                        o_tx_ready <= 1'b1;
                    end
                end

                // SS drops on the first SETUP edge; the first SCLK rise follows
                // CLK_DIV cycles later, so MOSI has a full half-period of setup.
                SETUP: begin
                    if (div_reg == '0) begin
                        o_ss   <= 1'b0;
                        o_mosi <= tx_sr_reg[WIDTH-1];
                    end
                    if (div_reg == DIV_FULL) begin
                        div_reg   <= '0;
                        o_sclk    <= 1'b1;
                        rx_sr_reg <= {rx_sr_reg[WIDTH-2:0], i_miso};
                        bit_reg   <= BIT_W'(1);
                        state_reg <= SHIFT;
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end

                SHIFT: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg <= '0;
                        if (o_sclk) begin
                            o_sclk <= 1'b0;
                            if (bit_reg != BIT_LAST) begin
                                tx_sr_reg <= {tx_sr_reg[WIDTH-2:0], 1'b0};
                                o_mosi    <= tx_sr_reg[WIDTH-2];
                            end
                        end else if (bit_reg == BIT_LAST) begin
                            // last low half-period complete
                            state_reg <= HOLD;
                        end else begin
                            o_sclk    <= 1'b1;
                            rx_sr_reg <= {rx_sr_reg[WIDTH-2:0], i_miso};
                            bit_reg   <= bit_reg + 1'b1;
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end

                HOLD: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg    <= '0;
                        gap_reg    <= '0;
                        o_ss       <= 1'b1;
                        o_rx_data  <= rx_sr_reg;
                        o_rx_valid <= 1'b1;
                        state_reg  <= GAP;
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end

                GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        o_busy     <= 1'b0;
                        o_tx_ready <= 1'b1;
                        state_reg  <= IDLE;
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_stream.sv
// Directed bench for spi_master_stream: loopback/tied MISO frames, held valid,
// ignored input while busy, and mid-frame asynchronous reset.
module tb_spi_master_stream;

    localparam int W   = 16;
    localparam int DIV = 2;
    localparam int GAP = 8;
    localparam int LAT = (2 * W + 2) * DIV + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic         sclk;
    logic         mosi;
    logic         ss;
    logic         miso;
    logic         loop_en = 1'b1;
    logic         miso_fix = 1'b0;

    assign miso = loop_en ? mosi : miso_fix;

    spi_master_stream #(.WIDTH(W), .CLK_DIV(DIV), .GAP_CYCLES(GAP)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst_n),
        .i_tx_data (tx_data),
        .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready),
        .o_rx_data (rx_data),
        .o_rx_valid(rx_valid),
        .o_busy    (busy),
        .o_sclk    (sclk),
        .o_mosi    (mosi),
        .o_ss      (ss),
        .i_miso    (miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];

    // slave-side observation state
    logic prev_ss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
    int   rises = 0, last_rises = 0, run = 0, min_gap = 1000;
    int   mode_viol = 0, rdy_viol = 0, rx_count = 0;
    bit   saw_frame = 0, mosi_hi = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            rises     = 0;
            run       = 0;
            saw_frame = 0;
            prev_ss   = 1'b1;
            prev_sclk = 1'b0;
        end else begin
            if (prev_sclk && sclk && mosi !== prev_mosi) mode_viol++;
            if (ss !== prev_ss && sclk !== 1'b0) mode_viol++;
            if (tx_ready && busy) rdy_viol++;
            if (prev_ss && !ss) begin
                if (saw_frame && run < min_gap) min_gap = run;
                rises   = 0;
                mosi_hi = 0;
            end
            if (!ss && !prev_sclk && sclk) rises++;
            if (!ss && mosi) mosi_hi = 1;
            if (!prev_ss && ss) begin
                last_rises = rises;
                saw_frame  = 1;
                run        = 0;
            end
            if (ss) run++;
            if (rx_valid) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected", 32'(rx_data), 32'hDEAD_0000);
                end else begin
                    logic [W-1:0] e;
                    int           a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    $display("rx frame %0d: data=0x%04h expected=0x%04h latency=%0d", rx_count, rx_data, e, cyc - a);
                    chk("rx_data", 32'(rx_data), 32'(e));
                    chk("rx_latency", 32'(cyc - a), 32'(LAT));
                end
            end
            prev_ss = ss;
            prev_sclk = sclk;
        end
        prev_mosi = mosi;
    end

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] expd, input bit hold);
        bit ok;
        ok = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (tx_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", 32'(ok), 32'd1);
        exp_q.push_back(expd);
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        bit ok;
        ok = 0;
        for (int n = 0; n < 1000; n++) begin
            if (rx_count >= target) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("frame_done", 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (tx_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_ready", 32'(ok), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int rc;
        int ready_seen;
        bit ok;

        repeat (3) @(negedge clk);
        chk("rst_ss", 32'(ss), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(tx_ready), 32'd1);

        // loopback single frame
        send(16'hA5C3, 16'hA5C3, 0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_frame(1);
        chk("rises_a5c3", 32'(last_rises), 32'd16);
        wait_idle();

        // MISO tied high, all-zero word
        loop_en  = 1'b0;
        miso_fix = 1'b1;
        send(16'h0000, 16'hFFFF, 0);
        wait_frame(2);
        chk("mosi_stays_low", 32'(mosi_hi), 32'd0);
        chk("rises_0000", 32'(last_rises), 32'd16);
        wait_idle();

        // held valid: back-to-back frames
        loop_en = 1'b1;
        min_gap = 1000;
        send(16'h0001, 16'h0001, 1);
        send(16'h8000, 16'h8000, 0);
        wait_frame(4);
        chk("ss_gap_min9", 32'(min_gap >= GAP + 1), 32'd1);
        wait_idle();

        // input churn during the frame is ignored
        send(16'h3C5A, 16'h3C5A, 0);
        ready_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (tx_ready) ready_seen++;
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = W'($urandom);
        end
        tx_valid = 1'b0;
        chk("ready_low_in_frame", 32'(ready_seen), 32'd0);
        wait_frame(5);
        wait_idle();

        // asynchronous reset after the 5th SCLK rise
        send(16'hBEEF, 16'hBEEF, 0);
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (rises >= 5) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_5th_rise", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ss", 32'(ss), 32'd1);
        chk("arst_sclk", 32'(sclk), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rx_data", 32'(rx_data), 32'd0);
        exp_q.delete();
        acc_q.delete();
        rc = rx_count;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_rx_after_reset", 32'(rx_count), 32'(rc));
        send(16'h1234, 16'h1234, 0);
        wait_frame(rc + 1);
        wait_idle();

        chk("mode0_violations", 32'(mode_viol), 32'd0);
        chk("ready_busy_overlap", 32'(rdy_viol), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_master_stream.md
Name: spi_master_stream

Overview:
- Host-side SPI master that drives the DFT/bandpower SPI slave port.
- Accepts parallel sample words on a valid/ready handshake and serialises each one onto MOSI as a single SS-framed word.
- Captures the slave's MISO reply for the same frame and presents it as a one-cycle-valid parallel word.
- Used in bench and loopback builds to stream samples into the slave and read back band-power results, one word per frame.

Parameters:
- WIDTH, 16, bits per SPI frame; MSB first; matches the slave's spi_s_width/spi_m_width.
- CLK_DIV, 4, i_sys_clk cycles per SCLK half-period; legal range 2..255.
- GAP_CYCLES, 8, minimum i_sys_clk cycles SS stays high between frames; legal range ≥1.

Ports:
- i_sys_clk  in  1  system clock; all logic on the rising edge.
- i_sys_rst  in  1  asynchronous reset, active-low.
- i_tx_data  in  WIDTH  word to transmit.
- i_tx_valid  in  1  i_tx_data is valid.
- o_tx_ready  out  1  block can accept a word; transfer happens when i_tx_valid & o_tx_ready.
- o_rx_data  out  WIDTH  word captured from MISO during the last frame.
- o_rx_valid  out  1  one-cycle pulse; o_rx_data is new.
- o_busy  out  1  high from accept until GAP ends.
- o_sclk  out  1  SPI clock, CPOL=0.
- o_mosi  out  1  master out.
- o_ss  out  1  slave select, active-low.
- i_miso  in  1  slave out.

Behaviour:
- Reset (async assert, sync release) values:
  - o_ss=1, o_sclk=0, o_mosi=0, o_tx_ready=0, o_busy=0, o_rx_valid=0, o_rx_data=0.
  - State = IDLE.
  - First cycle after release: o_tx_ready=1.
- SPI mode 0:
  - MOSI changes only while SCLK is low (at falling edges, or in SETUP).
  - MISO is sampled on the sys-clock cycle in which o_sclk goes 0->1.
  - No synchroniser on i_miso.
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE. A single divider counter (0..CLK_DIV-1) paces SETUP, SHIFT half-periods and HOLD.
- IDLE:
  - o_tx_ready=1.
  - On i_tx_valid & o_tx_ready: latch i_tx_data into the tx shift register, set o_tx_ready=0 and o_busy=1, go to SETUP.
- SETUP (CLK_DIV cycles):
  - o_ss=0 and o_mosi=tx[WIDTH-1] from the first SETUP cycle.
  - o_sclk stays 0.
- SHIFT (2*WIDTH half-periods of CLK_DIV cycles each):
  - o_sclk toggles at each half-period boundary.
  - Rising edge: shift i_miso into the LSB of the rx shift register.
  - Falling edge: present the next tx bit on o_mosi. After the final (WIDTH-th) falling edge, o_mosi holds its last value.
  - Exactly WIDTH rising edges per frame; the frame ends with o_sclk=0.
- HOLD (CLK_DIV cycles):
  - o_ss stays 0, o_sclk=0.
  - On exit: o_ss=1, o_rx_data <= rx shift register, o_rx_valid=1 for exactly one cycle.
- GAP (GAP_CYCLES cycles):
  - o_ss=1, o_tx_ready=0.
  - On exit: o_busy=0, o_tx_ready=1.
  - A held i_tx_valid is accepted in the first IDLE cycle, so back-to-back frames are separated by at least GAP_CYCLES+1 cycles of SS high.
- Latency:
  - o_ss falls 1 cycle after the accept edge.
  - o_rx_valid rises (2*WIDTH+2)*CLK_DIV+1 cycles after the accept edge.
- Input handling:
  - i_tx_valid and i_tx_data are ignored while o_tx_ready=0; no queueing.
  - i_tx_data may change freely after accept.
- Reset mid-frame: immediate o_ss=1, o_sclk=0, partial rx discarded, no o_rx_valid pulse; after release the block behaves as from power-up.
- o_rx_data holds its value until the next frame completes.

Test Plan:
- WIDTH=16, CLK_DIV=2, i_miso looped to o_mosi; send 0xA5C3 -> o_rx_data=0xA5C3 with a single o_rx_valid pulse at cycle 69 after accept; 16 SCLK rising edges observed while o_ss=0.
- i_miso tied 1, send 0x0000 -> o_rx_data=0xFFFF; o_mosi stays 0 throughout the frame.
- i_tx_valid held high with 0x0001 then 0x8000 (CLK_DIV=2, GAP_CYCLES=8) -> two frames; o_ss high for ≥9 cycles between them; o_rx_data sequence 0x0001, 0x8000 in loopback.
- Bench slave model checks mode 0 -> o_mosi never changes while o_sclk=1; o_sclk=0 whenever o_ss toggles.
- Assert reset after the 5th SCLK rising edge -> o_ss=1 and o_sclk=0 asynchronously; no o_rx_valid pulse; next frame 0x1234 (loopback) returns 0x1234.
- Toggle i_tx_valid with changing data during SHIFT -> ignored; o_tx_ready=0 until GAP ends; the transmitted word equals the word latched at accept.
